write_back_stage: RTL and testbench
===================================

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register-file data width.
REQ-002 SHALL have parameter REG_W, default 4, meaning register index width (16 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port en  input  1  stage enable; 0 holds all state.
REQ-006 SHALL have port flush  input  1  replace the incoming instruction with a bubble.
REQ-007 SHALL have port instClass  input  5  class code from the memory stage.
REQ-008 SHALL have port opCode  input  4  opcode from the memory stage.
REQ-009 SHALL have port RdIn  input  REG_W  destination register from the memory stage.
REQ-010 SHALL have port aluResult  input  DATA_W  ALU result from the memory stage.
REQ-011 SHALL have port memData  input  DATA_W  load data from the memory stage.
REQ-012 SHALL have port WE  output  1  register-file write enable into instructionDecode.
REQ-013 SHALL have port Rd  output  REG_W  register-file write index into instructionDecode.
REQ-014 SHALL have port WD  output  DATA_W  register-file write data into instructionDecode.
REQ-015 SHALL have port retired  output  32  count of non-bubble instructions retired.
REQ-016 SHALL have port illegal  output  1  sticky flag for an unknown class code.

Function
REQ-017 SHALL use these class codes: NOP 00000, ALU_REG 00001, ALU_IMM 10001, MEM 00011, BRANCH 11000; any other code is illegal.
REQ-018 SHALL latch all inputs into the stage register on each posedge with en=1 and rst=0, giving one-cycle latency from input to WE/Rd/WD.
REQ-019 SHALL latch class NOP instead of instClass when flush=1 and en=1; flush SHALL take priority over the input class.
REQ-020 SHALL hold the stage register, retired and illegal unchanged when en=0, including while flush=1.
REQ-021 SHALL drive WE=1 only for latched ALU_REG, ALU_IMM, or MEM with opCode 0010 (ld); store, BRANCH, NOP and illegal SHALL give WE=0.
REQ-022 SHALL drive WD=memData for a MEM load and WD=aluResult otherwise.
REQ-023 SHALL drive Rd=latched RdIn; Rd and WD SHALL be don't-care-free, so with WE=0 they still show the latched values.
REQ-024 SHALL permit writes to r0, with no special casing.
REQ-025 SHALL take WE, Rd and WD directly from registers; they SHALL be stable for a full clock period.
REQ-026 SHALL increment retired by 1 on each enabled posedge that latches a non-NOP class, including an illegal class; retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 SHALL set illegal on the enabled posedge that latches an unknown class, and it SHALL stay set until rst.
REQ-028 SHALL treat flush=1 on the same cycle as an illegal class as a bubble: no illegal flag set and no count.

Reset
REQ-029 SHALL, on posedge with rst=1 and regardless of en or flush, clear the stage to NOP with Rd=0 and the data registers to 0, so that WE=0, Rd=0 and WD=0.
REQ-030 SHALL clear retired to 0 and illegal to 0 on reset.
REQ-031 SHALL abandon any instruction in flight on reset mid-operation, with no write issued on that cycle or the next.

Structure
REQ-032 SHALL take class-code constants, the ld/str opcode constants and the DATA_W/REG_W defaults from the shared package cpu_pkg, which instructionDecode also uses.
REQ-033 SHALL build the stage register from one sub-module, pipe_reg, a parameterised enabled register with synchronous reset.

Verification
REQ-034 SHALL verify reset: assert rst for 2 cycles with valid inputs -> WE=0, Rd=0, WD=0, retired=0, illegal=0.
REQ-035 SHALL verify ALU write: ALU_IMM, RdIn=1010, aluResult=0x0000000F -> next cycle WE=1, Rd=1010, WD=0x0000000F, retired=1.
REQ-036 SHALL verify load versus store: MEM, opCode 0010, RdIn=1111, memData=0xDEADBEEF -> WE=1, WD=0xDEADBEEF; then MEM with opCode 0011 -> WE=0, retired +1.
REQ-037 SHALL verify branch and NOP: BRANCH then NOP -> WE=0 both cycles, retired +1 then +0.
REQ-038 SHALL verify flush and enable: flush=1 with ALU_REG -> WE=0 and no count; en=0 for 3 cycles -> outputs frozen.
REQ-039 SHALL verify illegal and wrap: class 01010 -> illegal=1 and still 1 after 5 NOP cycles; preload the counter to 0xFFFFFFFF, retire one instruction -> retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: class codes, memory opcodes, widths.
// Used by instructionDecode and write_back_stage.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  localparam logic [4:0] CLS_NOP     = 5'b00000;
  localparam logic [4:0] CLS_ALU_REG = 5'b00001;
  localparam logic [4:0] CLS_ALU_IMM = 5'b10001;
  localparam logic [4:0] CLS_MEM     = 5'b00011;
  localparam logic [4:0] CLS_BRANCH  = 5'b11000;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_STR = 4'b0011;

  function automatic logic cls_known(
    input logic [4:0] c
  );
    return (c == CLS_NOP)
        || (c == CLS_ALU_REG)
        || (c == CLS_ALU_IMM)
        || (c == CLS_MEM)
        || (c == CLS_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Parameterised enabled register with synchronous reset.
// Reset wins over enable.
module pipe_reg #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: registers the register-file write port,
// counts retired instructions and flags unknown classes.
module write_back_stage
  import cpu_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          REG_W       = REG_W_DEF,
  parameter logic [31:0] RETIRED_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [4:0]        instClass,
  input  logic [3:0]        opCode,
  input  logic [REG_W-1:0]  RdIn,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] memData,
  output logic              WE,
  output logic [REG_W-1:0]  Rd,
  output logic [DATA_W-1:0] WD,
  output logic [31:0]       retired,
  output logic              illegal
);

  localparam int ST_W = 1 + REG_W + DATA_W;

  logic [4:0]        cls_d;
  logic              ld_d;
  logic              we_d;
  logic [DATA_W-1:0] wd_d;
  logic [ST_W-1:0]   st_d;
  logic [ST_W-1:0]   st_q;
  logic [31:0]       retired_d;
  logic [31:0]       retired_q;
  logic              illegal_d;
  logic              illegal_q;

  // A flushed slot is latched as a bubble.
  assign cls_d = flush ? CLS_NOP : instClass;
  assign ld_d  = (cls_d == CLS_MEM)
              && (opCode == OP_LD);

  always_comb begin
    we_d = 1'b0;
    unique case (1'b1)
      (cls_d == CLS_ALU_REG): we_d = 1'b1;
      (cls_d == CLS_ALU_IMM): we_d = 1'b1;
      ld_d:                   we_d = 1'b1;
      default:                we_d = 1'b0;
    endcase
  end

  assign wd_d = ld_d ? memData : aluResult;
  assign st_d = {we_d, RdIn, wd_d};

  pipe_reg #(
    .W       (ST_W),
    .RST_VAL ('0)
  ) u_st (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (st_d),
    .q   (st_q)
  );

  always_comb begin
    retired_d = retired_q;
    illegal_d = illegal_q;
    if (en) begin
      if (cls_d != CLS_NOP) begin
        retired_d = retired_q + 32'd1;
      end
      if (!cls_known(cls_d)) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= RETIRED_RST;
      illegal_q <= 1'b0;
    end else begin
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign WE      = st_q[ST_W-1];
  assign Rd      = st_q[DATA_W +: REG_W];
  assign WD      = st_q[DATA_W-1:0];
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage.
// Table vectors plus reset and wrap sequences.
module tb_write_back_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [4:0]  instClass;
  logic [3:0]  opCode;
  logic [3:0]  RdIn;
  logic [31:0] aluResult;
  logic [31:0] memData;
  logic        WE;
  logic [3:0]  Rd;
  logic [31:0] WD;
  logic [31:0] retired;
  logic        illegal;
  logic        WE2;
  logic [3:0]  Rd2;
  logic [31:0] WD2;
  logic [31:0] retired2;
  logic        illegal2;

  int n_vec;
  int n_err;

  write_back_stage dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .instClass (instClass),
    .opCode    (opCode),
    .RdIn      (RdIn),
    .aluResult (aluResult),
    .memData   (memData),
    .WE        (WE),
    .Rd        (Rd),
    .WD        (WD),
    .retired   (retired),
    .illegal   (illegal)
  );

  write_back_stage #(
    .RETIRED_RST (32'hFFFF_FFFF)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .instClass (instClass),
    .opCode    (opCode),
    .RdIn      (RdIn),
    .aluResult (aluResult),
    .memData   (memData),
    .WE        (WE2),
    .Rd        (Rd2),
    .WD        (WD2),
    .retired   (retired2),
    .illegal   (illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        flush;
    logic [4:0]  cls;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        e_we;
    logic [3:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_ret;
    logic        e_ill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic        r,
    input logic        e,
    input logic        f,
    input logic [4:0]  c,
    input logic [3:0]  o,
    input logic [3:0]  d,
    input logic [31:0] a,
    input logic [31:0] m,
    input logic        xwe,
    input logic [3:0]  xrd,
    input logic [31:0] xwd,
    input logic [31:0] xret,
    input logic        xill
  );
    vec_t v;
    v.rst = r; v.en = e; v.flush = f;
    v.cls = c; v.op = o; v.rd = d;
    v.alu = a; v.mem = m;
    v.e_we = xwe; v.e_rd = xrd;
    v.e_wd = xwd; v.e_ret = xret;
    v.e_ill = xill;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(
    input logic        r,
    input logic        e,
    input logic        f,
    input logic [4:0]  c,
    input logic [3:0]  o,
    input logic [3:0]  d,
    input logic [31:0] a,
    input logic [31:0] m
  );
    rst = r; en = e; flush = f;
    instClass = c; opCode = o; RdIn = d;
    aluResult = a; memData = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input int          idx,
    input logic        xwe,
    input logic [3:0]  xrd,
    input logic [31:0] xwd,
    input logic [31:0] xret,
    input logic        xill
  );
    chk("WE", idx, {31'd0, WE}, {31'd0, xwe});
    chk("Rd", idx, {28'd0, Rd}, {28'd0, xrd});
    chk("WD", idx, WD, xwd);
    chk("retired", idx, retired, xret);
    chk("illegal", idx, {31'd0, illegal},
        {31'd0, xill});
  endtask

  localparam logic [4:0] ILL = 5'b01010;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    instClass = CLS_NOP; opCode = '0; RdIn = '0;
    aluResult = '0; memData = '0;

    // reset twice with valid inputs
    tbl.push_back(mk(1,1,0,CLS_ALU_IMM,0,4'h5,32'h55,32'h0,
                     0,4'h0,32'h0,0,0));
    tbl.push_back(mk(1,1,0,CLS_ALU_IMM,0,4'h5,32'h55,32'h0,
                     0,4'h0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,CLS_ALU_IMM,0,4'hA,32'hF,32'h0,
                     1,4'hA,32'hF,1,0));
    tbl.push_back(mk(0,1,0,CLS_MEM,OP_LD,4'hF,32'h123,
                     32'hDEADBEEF,
                     1,4'hF,32'hDEADBEEF,2,0));
    tbl.push_back(mk(0,1,0,CLS_MEM,OP_STR,4'h3,32'h40,32'h77,
                     0,4'h3,32'h40,3,0));
    tbl.push_back(mk(0,1,0,CLS_BRANCH,0,4'h2,32'h100,32'h0,
                     0,4'h2,32'h100,4,0));
    tbl.push_back(mk(0,1,0,CLS_NOP,0,4'h1,32'h9,32'h0,
                     0,4'h1,32'h9,4,0));
    tbl.push_back(mk(0,1,1,CLS_ALU_REG,0,4'h6,32'h66,32'h0,
                     0,4'h6,32'h66,4,0));
    tbl.push_back(mk(0,1,0,CLS_ALU_REG,0,4'h0,32'hCAFE,32'h0,
                     1,4'h0,32'hCAFE,5,0));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(0,0,1,CLS_ALU_REG,0,4'h7,32'hBAD,32'h1,
                       1,4'h0,32'hCAFE,5,0));
    end
    tbl.push_back(mk(0,0,0,ILL,OP_LD,4'h8,32'h2,32'h3,
                     1,4'h0,32'hCAFE,5,0));
    tbl.push_back(mk(0,1,1,ILL,0,4'h4,32'h11,32'h0,
                     0,4'h4,32'h11,5,0));
    tbl.push_back(mk(0,1,0,ILL,0,4'h9,32'h22,32'h0,
                     0,4'h9,32'h22,6,1));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(0,1,0,CLS_NOP,0,4'h0,32'h0,32'h0,
                       0,4'h0,32'h0,6,1));
    end
    tbl.push_back(mk(1,0,1,CLS_ALU_IMM,0,4'hC,32'h5,32'h6,
                     0,4'h0,32'h0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].flush,
            tbl[i].cls, tbl[i].op, tbl[i].rd,
            tbl[i].alu, tbl[i].mem);
      chk_all(i, tbl[i].e_we, tbl[i].e_rd,
              tbl[i].e_wd, tbl[i].e_ret, tbl[i].e_ill);
    end

    // reset in the middle of a write stream
    drive(0,1,0,CLS_ALU_REG,0,4'h3,32'h33,32'h0);
    chk_all(100, 1, 4'h3, 32'h33, 1, 0);
    drive(1,1,0,CLS_ALU_REG,0,4'h4,32'h44,32'h0);
    chk_all(101, 0, 4'h0, 32'h0, 0, 0);
    drive(0,0,0,CLS_ALU_REG,0,4'h5,32'h55,32'h0);
    chk_all(102, 0, 4'h0, 32'h0, 0, 0);

    // counter wrap on the preloaded instance
    drive(1,1,0,CLS_NOP,0,4'h0,32'h0,32'h0);
    chk("retired2", 200, retired2, 32'hFFFF_FFFF);
    drive(0,1,0,CLS_ALU_IMM,0,4'h2,32'h7,32'h0);
    chk("retired2", 201, retired2, 32'h0);
    chk("WE2", 201, {31'd0, WE2}, 32'd1);
    drive(0,1,0,CLS_NOP,0,4'h0,32'h0,32'h0);
    chk("retired2", 202, retired2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
